// File: rtl/rct_wb_timeout_guard.sv
// Wishbone classic guard in front of the test-IO slave: zero-latency pass-through,
// aborts unanswered requests after TIMEOUT_CYC cycles. Optional IRQ: RCT_WB_TO_IRQ_EN.
module rct_wb_timeout_guard #(
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_MASK    = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 m_wb_stb_i,
  input  logic                 m_wb_cyc_i,
  input  logic                 m_wb_we_i,
  input  logic [BUS_WIDTH-1:0] m_wb_addr_i,
  input  logic [BUS_WIDTH-1:0] m_wb_data_i,
  input  logic [BUS_MASK-1:0]  m_wb_sel_i,
  output logic                 m_wb_ack_o,
  output logic                 m_wb_err_o,
  output logic [BUS_WIDTH-1:0] m_wb_data_o,
  output logic                 s_wb_stb_o,
  output logic                 s_wb_cyc_o,
  output logic                 s_wb_we_o,
  output logic [BUS_WIDTH-1:0] s_wb_addr_o,
  output logic [BUS_WIDTH-1:0] s_wb_data_o,
  output logic [BUS_MASK-1:0]  s_wb_sel_o,
  input  logic                 s_wb_ack_i,
  input  logic                 s_wb_err_i,
  input  logic [BUS_WIDTH-1:0] s_wb_data_i,
  input  logic                 to_clr_i,
  output logic                 to_flag_o,
  output logic [BUS_WIDTH-1:0] to_addr_o,
  output logic [CNT_W-1:0]     to_cnt_o
`ifdef RCT_WB_TO_IRQ_EN
  ,
  output logic                 to_irq_o
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]    LAST_CNT = CW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          req;
  logic          rsp;
  logic          to_hit;

  assign req    = m_wb_cyc_i & m_wb_stb_i;
  assign rsp    = s_wb_ack_i | s_wb_err_i;
  // The last permitted wait cycle passes without a response: abort on the next edge.
  assign to_hit = (state != ST_ABORT) & req & ~rsp & (wait_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      to_flag_o <= 1'b0;
      to_addr_o <= '0;
      to_cnt_o  <= '0;
`ifdef RCT_WB_TO_IRQ_EN
      to_irq_o  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE:  if (to_hit) state <= ST_ABORT;
                  else if (req && !rsp) state <= ST_WAIT;
        ST_WAIT:  if (to_hit) state <= ST_ABORT;
                  else if (!req) state <= ST_IDLE;
        ST_ABORT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (state == ST_ABORT || !req || rsp || to_hit) wait_cnt <= '0;
      else                                             wait_cnt <= wait_cnt + 1'b1;

      // A timeout in the same cycle as a clear takes precedence and counts as the first event.
      if (to_hit) begin
        to_flag_o <= 1'b1;
        to_addr_o <= m_wb_addr_i;
        if (to_clr_i)                 to_cnt_o <= CNT_W'(1);
        else if (to_cnt_o != CNT_MAX) to_cnt_o <= to_cnt_o + 1'b1;
      end else if (to_clr_i) begin
        to_flag_o <= 1'b0;
        to_addr_o <= '0;
        to_cnt_o  <= '0;
      end
`ifdef RCT_WB_TO_IRQ_EN
      to_irq_o <= to_hit;
`endif
    end
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    s_wb_stb_o  = 1'b0;
    s_wb_cyc_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_addr_o = '0;
    s_wb_data_o = '0;
    s_wb_sel_o  = '0;
    m_wb_ack_o  = 1'b0;
    m_wb_err_o  = 1'b0;
    m_wb_data_o = '0;
    // Reset gates the combinational paths too, so a reset mid-cycle drops the bus at once.
    if (rstn_i) begin
      if (state == ST_ABORT) begin
        m_wb_err_o = 1'b1;
      end else begin
        s_wb_stb_o  = m_wb_stb_i;
        s_wb_cyc_o  = m_wb_cyc_i;
        s_wb_we_o   = m_wb_we_i;
        s_wb_addr_o = m_wb_addr_i;
        s_wb_data_o = m_wb_data_i;
        s_wb_sel_o  = m_wb_sel_i;
        m_wb_ack_o  = s_wb_ack_i & req;
        m_wb_err_o  = s_wb_err_i & req;
        m_wb_data_o = s_wb_data_i;
      end
    end
  end

endmodule

// File: tb/tb_rct_wb_timeout_guard.sv
// Self-checking bench for rct_wb_timeout_guard (TIMEOUT_CYC=4, CNT_W=2): directed
// scenarios plus randomized requests against a request-level reference model.
module tb_rct_wb_timeout_guard;

  localparam int T   = 4;
  localparam int CW  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        m_stb = 1'b0, m_cyc = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_sel = '0;
  logic        m_ack, m_err;
  logic [31:0] m_rdata;
  logic        s_stb, s_cyc, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_ack = 1'b0, s_err = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        to_clr = 1'b0;
  logic        to_flag;
  logic [31:0] to_addr;
  logic [CW-1:0] to_cnt;
`ifdef RCT_WB_TO_IRQ_EN
  logic        to_irq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference status, updated per request from the timeout rules.
  logic        exp_flag = 1'b0;
  logic [31:0] exp_addr = '0;
  int          exp_cnt  = 0;

  rct_wb_timeout_guard #(.BUS_WIDTH(32), .BUS_MASK(4), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m_wb_stb_i(m_stb), .m_wb_cyc_i(m_cyc), .m_wb_we_i(m_we),
    .m_wb_addr_i(m_addr), .m_wb_data_i(m_wdata), .m_wb_sel_i(m_sel),
    .m_wb_ack_o(m_ack), .m_wb_err_o(m_err), .m_wb_data_o(m_rdata),
    .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc), .s_wb_we_o(s_we),
    .s_wb_addr_o(s_addr), .s_wb_data_o(s_wdata), .s_wb_sel_o(s_sel),
    .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_data_i(s_rdata),
    .to_clr_i(to_clr), .to_flag_o(to_flag), .to_addr_o(to_addr), .to_cnt_o(to_cnt)
`ifdef RCT_WB_TO_IRQ_EN
    , .to_irq_o(to_irq)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".flag"}, to_flag, exp_flag);
    check({tag, ".addr"}, to_addr, exp_addr);
    check({tag, ".cnt"},  to_cnt,  exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".bus"}, {s_stb, s_cyc, s_we, s_sel, m_ack, m_err}, '0);
    check({tag, ".saddr"}, s_addr, '0);
    check({tag, ".swdata"}, s_wdata, '0);
    check({tag, ".mrdata"}, m_rdata, '0);
    check({tag, ".status"}, {to_flag, to_addr, to_cnt}, '0);
`ifdef RCT_WB_TO_IRQ_EN
    check({tag, ".irq"}, to_irq, 1'b0);
`endif
  endtask

  // One master request; the slave answers in cycle lat (lat >= T: never in time).
  task automatic run_req(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wd, input int lat, input bit rsp_err,
                         input logic [31:0] rd, input bit clr_at_hit, input bit late_ack);
    bit timed_out;
    int last;
    logic [3:0] sel;
    timed_out = (lat >= T);
    last = timed_out ? T : lat;
    sel = 4'($urandom_range(1, 15));
    for (int k = 0; k <= last; k++) begin
      m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_sel = sel;
      s_rdata = rd;
      s_ack = !timed_out && k == lat && !rsp_err;
      s_err = !timed_out && k == lat && rsp_err;
      if (timed_out && k == T) s_ack = late_ack;
      to_clr = clr_at_hit && timed_out && k == T - 1;
      @(negedge clk_i);
      check({tag, ".s_stb"}, s_stb, k < T);
      check({tag, ".s_cyc"}, s_cyc, k < T);
      check({tag, ".s_req"}, {s_we, s_addr, s_wdata, s_sel},
            (k < T) ? {we, addr, wd, sel} : 69'd0);
      check({tag, ".m_ack"}, m_ack, !timed_out && k == lat && !rsp_err);
      check({tag, ".m_err"}, m_err, (!timed_out && k == lat && rsp_err) || k == T);
      check({tag, ".m_data"}, m_rdata, (k == T) ? 32'd0 : rd);
`ifdef RCT_WB_TO_IRQ_EN
      check({tag, ".irq"}, to_irq, timed_out && k == T);
`endif
      tick();
    end
    if (timed_out) begin
      exp_flag = 1'b1;
      exp_addr = addr;
      exp_cnt  = clr_at_hit ? 1 : (exp_cnt == MAXC ? MAXC : exp_cnt + 1);
    end
    // Master drops the request; a stray late ack must be swallowed.
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = late_ack; s_err = 1'b0; to_clr = 1'b0;
    @(negedge clk_i);
    check({tag, ".idle_ack"}, m_ack, 1'b0);
    check({tag, ".idle_err"}, m_err, 1'b0);
    check({tag, ".idle_stb"}, s_stb, 1'b0);
    check_status(tag);
    tick();
    s_ack = 1'b0;
  endtask

  // Master holds an unanswered request for n cycles, then drops stb.
  task automatic abandon(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h0000_0BAD; s_ack = 1'b0; s_err = 1'b0;
      @(negedge clk_i);
      check({tag, ".err"}, m_err, 1'b0);
      tick();
    end
    m_stb = 1'b0;
    @(negedge clk_i);
    check({tag, ".drop_err"}, m_err, 1'b0);
    check({tag, ".drop_stb"}, s_stb, 1'b0);
    check_status(tag);
    tick();
    m_cyc = 1'b0;
  endtask

  initial begin
    // Reset with a live request and slave response on the inputs: everything reads 0.
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h1234_5678; m_wdata = 32'hFFFF_0000;
    m_sel = 4'hF; m_we = 1'b1; s_ack = 1'b1; s_err = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    rstn_i = 1'b1;
    tick();

    run_req("rd_ack2",   32'h10, 1'b0, 32'h0,  2, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
    run_req("wr_to",     32'h24, 1'b1, 32'h77, T, 1'b0, 32'h0,         1'b0, 1'b1);
    run_req("ack_last",  32'h30, 1'b0, 32'h0,  T - 1, 1'b0, 32'h0000_C0DE, 1'b0, 1'b0);
    run_req("err_last",  32'h34, 1'b1, 32'h5,  T - 1, 1'b1, 32'h0000_0E44, 1'b0, 1'b0);
    run_req("ack0",      32'h38, 1'b0, 32'h0,  0, 1'b0, 32'h0000_0001, 1'b0, 1'b0);

    abandon("abandon2", 2);
    run_req("after_ab1", 32'h40, 1'b0, 32'h0,  1, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
    abandon("abandon3", 3);
    run_req("after_ab3", 32'h44, 1'b0, 32'h0,  T - 1, 1'b0, 32'h3333_4444, 1'b0, 1'b0);

    // Four more timeouts (five total) saturate the 2-bit counter.
    for (int i = 0; i < 4; i++)
      run_req("sat", 32'h100 + 32'(i), 1'b0, 32'h0, T + 1, 1'b0, 32'h0, 1'b0, i[0]);
    check("sat_cnt", to_cnt, 2'd3);
    run_req("clr_hit",   32'h200, 1'b1, 32'h9, T, 1'b0, 32'h0, 1'b1, 1'b0);
    check("clr_hit_cnt", to_cnt, 2'd1);

    to_clr = 1'b1;
    tick();
    to_clr = 1'b0;
    exp_flag = 1'b0; exp_addr = '0; exp_cnt = 0;
    @(negedge clk_i);
    check_status("clr_idle");
    tick();

    for (int i = 0; i < 30; i++) begin
      int lat;
      lat = int'($urandom_range(0, T + 1));
      run_req("rand", $urandom, 1'($urandom), $urandom, lat, 1'($urandom),
              $urandom, ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Reset asserted in cycle 2 of a pending request.
    for (int k = 0; k < 2; k++) begin
      m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h0000_0555; s_rdata = 32'hCAFE_0000;
      @(negedge clk_i);
      check("rst_mid.pend", s_stb, 1'b1);
      tick();
    end
    #2;
    rstn_i = 1'b0;
    #1;
    exp_flag = 1'b0; exp_addr = '0; exp_cnt = 0;
    check_all_zero("rst_mid");
    @(negedge clk_i);
    check_all_zero("rst_mid_hold");
    m_cyc = 1'b0; m_stb = 1'b0;
    rstn_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("rst_after.err", m_err, 1'b0);
    check_status("rst_after");
    tick();
    run_req("post_rst",  32'h60, 1'b0, 32'h0, 1, 1'b0, 32'h6060_6060, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
